div_seq: RTL

Iterative 32-bit integer divide sequencer beside the execute stage. It accepts one divide/modulo request per valid/ready handshake and runs a one-bit-per-cycle restoring divide. It presents the quotient or remainder with its writeback tag on an output handshake toward the memory stage. It also drives a busy indication, which EXE uses to hold the pipeline, and aborts on a branch flush.

---
 rtl/div_seq_pkg.sv | 24 ++
 rtl/div_step.sv | 24 ++
 rtl/div_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative divide sequencer: widths, op bit positions, FSM states.
package div_seq_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned TAG_W     = 5;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned OP_SIGNED = 0;
    localparam int unsigned OP_REM    = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_e;

    // Unsigned magnitude of an operand; two's-complement abs only for signed ops.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                  input logic            is_signed);
        return (is_signed && x[XLEN-1]) ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-divide step: shift {rem, quo} left, trial-subtract the divisor.
module div_step
    import div_seq_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0]   w_shifted;
    logic [XLEN+1:0] w_diff;
    logic            w_fits;

    // The shifted remainder needs one extra bit before the compare.
    assign w_shifted = {i_rem, i_quo[XLEN-1]};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor};
    assign w_fits    = ~w_diff[XLEN+1];

    assign o_rem = w_fits ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/div_seq.sv
// Iterative 32-bit divide/modulo sequencer with valid/ready handshakes and flush abort.
// Optional DIV_EARLY_OUT_EN: resolve divide-by-zero and |src1| < |src2| directly at accept.
module div_seq
    import div_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    input  logic [TAG_W-1:0]  wreg_index,
    input  logic              wreg_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [TAG_W-1:0]  out_wreg_index,
    output logic              out_wreg_en,
    output logic              busy
);

    div_state_e         r_state,   w_state_d;
    logic               r_op_rem,  w_op_rem_d;
    logic               r_neg_q,   w_neg_q_d;
    logic               r_neg_r,   w_neg_r_d;
    logic               r_div0,    w_div0_d;
    logic [TAG_W-1:0]   r_tag_idx, w_tag_idx_d;
    logic               r_tag_en,  w_tag_en_d;
    logic [XLEN-1:0]    r_src1,    w_src1_d;
    logic [XLEN-1:0]    r_rem,     w_rem_d;
    logic [XLEN-1:0]    r_quo,     w_quo_d;
    logic [XLEN-1:0]    r_dvsr,    w_dvsr_d;
    logic [CNT_W-1:0]   r_cnt,     w_cnt_d;
    logic [XLEN-1:0]    r_result,  w_result_d;
    logic [TAG_W-1:0]   r_out_idx, w_out_idx_d;
    logic               r_out_en,  w_out_en_d;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_out_valid;

    logic [XLEN-1:0]    w_mag1;
    logic [XLEN-1:0]    w_mag2;
    logic [XLEN-1:0]    w_step_rem;
    logic [XLEN-1:0]    w_step_quo;
    logic [XLEN-1:0]    w_fix_quo;
    logic [XLEN-1:0]    w_fix_rem;
    logic [XLEN-1:0]    w_fix_result;

    assign w_mag1 = magnitude(src1, op[OP_SIGNED]);
    assign w_mag2 = magnitude(src2, op[OP_SIGNED]);

    div_step u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dvsr),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    // Sign correction; divide-by-zero overrides both results.
    assign w_fix_quo    = r_div0 ? '1     : (r_neg_q ? XLEN'(-r_quo) : r_quo);
    assign w_fix_rem    = r_div0 ? r_src1 : (r_neg_r ? XLEN'(-r_rem) : r_rem);
    assign w_fix_result = r_op_rem ? w_fix_rem : w_fix_quo;

`ifdef DIV_EARLY_OUT_EN
    logic            w_early;
    logic [XLEN-1:0] w_early_result;
    assign w_early        = (src2 == '0) || (w_mag1 < w_mag2);
    assign w_early_result = op[OP_REM] ? src1 : ((src2 == '0) ? '1 : '0);
`endif

    // Next-state and datapath update.
    always_comb begin
        w_state_d   = r_state;
        w_op_rem_d  = r_op_rem;
        w_neg_q_d   = r_neg_q;
        w_neg_r_d   = r_neg_r;
        w_div0_d    = r_div0;
        w_tag_idx_d = r_tag_idx;
        w_tag_en_d  = r_tag_en;
        w_src1_d    = r_src1;
        w_rem_d     = r_rem;
        w_quo_d     = r_quo;
        w_dvsr_d    = r_dvsr;
        w_cnt_d     = r_cnt;
        w_result_d  = r_result;
        w_out_idx_d = r_out_idx;
        w_out_en_d  = r_out_en;

        if (flush) begin
            w_state_d = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        w_op_rem_d  = op[OP_REM];
                        w_neg_q_d   = op[OP_SIGNED] & (src1[XLEN-1] ^ src2[XLEN-1]);
                        w_neg_r_d   = op[OP_SIGNED] & src1[XLEN-1];
                        w_div0_d    = (src2 == '0);
                        w_tag_idx_d = wreg_index;
                        w_tag_en_d  = wreg_en;
                        w_src1_d    = src1;
                        w_rem_d     = '0;
                        w_quo_d     = w_mag1;
                        w_dvsr_d    = w_mag2;
                        w_cnt_d     = CNT_W'(XLEN - 1);
                        w_state_d   = RUN;
`ifdef DIV_EARLY_OUT_EN
                        if (w_early) begin
                            w_result_d  = w_early_result;
                            w_out_idx_d = wreg_index;
                            w_out_en_d  = wreg_en;
                            w_state_d   = DONE;
                        end
`endif
                    end
                end
                RUN: begin
                    w_rem_d = w_step_rem;
                    w_quo_d = w_step_quo;
                    w_cnt_d = r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        w_state_d = FIX;
                    end
                end
                FIX: begin
                    w_result_d  = w_fix_result;
                    w_out_idx_d = r_tag_idx;
                    w_out_en_d  = r_tag_en;
                    w_state_d   = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_d = IDLE;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div0      <= 1'b0;
            r_tag_idx   <= '0;
            r_tag_en    <= 1'b0;
            r_src1      <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_idx   <= '0;
            r_out_en    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_op_rem    <= w_op_rem_d;
            r_neg_q     <= w_neg_q_d;
            r_neg_r     <= w_neg_r_d;
            r_div0      <= w_div0_d;
            r_tag_idx   <= w_tag_idx_d;
            r_tag_en    <= w_tag_en_d;
            r_src1      <= w_src1_d;
            r_rem       <= w_rem_d;
            r_quo       <= w_quo_d;
            r_dvsr      <= w_dvsr_d;
            r_cnt       <= w_cnt_d;
            r_result    <= w_result_d;
            r_out_idx   <= w_out_idx_d;
            r_out_en    <= w_out_en_d;
            r_in_ready  <= (w_state_d == IDLE);
            r_busy      <= (w_state_d != IDLE);
            r_out_valid <= (w_state_d == DONE);
        end
    end

    assign in_ready       = r_in_ready;
    assign busy           = r_busy;
    assign out_valid      = r_out_valid;
    assign result         = r_result;
    assign out_wreg_index = r_out_idx;
    assign out_wreg_en    = r_out_en;

endmodule
